// File: rtl/op_issue_pkg.sv
// op_issue_pkg: opcode, condition-code and FSM encodings shared by the issue stage
package op_issue_pkg;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_AL = 4'b1110;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE, S_WB} state_t;
  function automatic logic cond_legal(input logic [3:0] c, input bit allow);
    return allow ? (c inside {CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_AL}) : c == CC_AL;
  endfunction
  function automatic logic cond_pass(input logic [3:0] c, input logic [2:0] nzc);
    return c == CC_EQ ? nzc[1] : c == CC_NE ? !nzc[1] :
           c == CC_CS ? nzc[0] : c == CC_CC ? !nzc[0] :
           c == CC_MI ? nzc[2] : c == CC_PL ? !nzc[2] : c == CC_AL;
  endfunction
endpackage

// File: rtl/op_regfile.sv
// op_regfile: register file with two registered read ports, one write port and a combinational debug read
module op_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [AW-1:0]     ra_a,
  input  logic [AW-1:0]     ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] mem [NREGS];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      if (we) mem[wa] <= wd;
      if (re) begin
        rd_a <= mem[ra_a];
        rd_b <= mem[ra_b];
      end
    end
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/op_issue.sv
// op_issue: decode, condition check and issue of ADD/ADC words to op_add, with writeback and flag register
module op_issue
  import op_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS = 16,
  parameter bit ALLOW_CC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              ex_en_inst,
  output logic              ex_imm,
  output logic [4:0]        ex_instruction,
  output logic              ex_s,
  output logic [DATA_W-1:0] ex_rn,
  output logic [DATA_W-1:0] ex_rm,
  output logic [11:0]       ex_imm_operand,
  output logic [4:0]        ex_imm_shift,
  output logic [1:0]        ex_stype,
  output logic              ex_carry_in,
  output logic              ex_zero_in,
  output logic              ex_neg_in,
  input  logic [DATA_W-1:0] ex_rd,
  input  logic              ex_carry_out,
  input  logic              ex_zero_out,
  input  logic              ex_neg_out,
  output logic              retire,
  output logic              skipped,
  output logic              illegal,
  output logic [2:0]        flags,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_t state, state_n;
  logic [31:0] ir;
  logic [2:0] nzc;
  logic [3:0] cond, op, rn, rd, rm;
  logic i_bit, bad, go, wb;
  assign cond = ir[31:28];
  assign i_bit = ir[25];
  assign op = ir[24:21];
  assign rn = ir[19:16];
  assign rd = ir[15:12];
  assign rm = ir[3:0];
  assign in_ready = state == S_IDLE;
  assign wb = state == S_WB;
  assign flags = nzc;
  assign {ex_neg_in, ex_zero_in, ex_carry_in} = nzc;
  assign bad = ir[27:26] != 2'b00 || !(op == OP_ADD || op == OP_ADC) || (!i_bit && ir[4]) ||
               rn == 4'd15 || rd == 4'd15 || (!i_bit && rm == 4'd15) || !cond_legal(cond, ALLOW_CC);
  assign go = state == S_DECODE && !bad && cond_pass(cond, nzc);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   state_n = in_valid ? S_DECODE : S_IDLE;
      S_DECODE: state_n = go ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_n = S_WB;
      default:  state_n = S_IDLE;
    endcase
  end
  // operand data comes from the regfile read ports, enabled by the same go that captures the fields
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ir <= '0;
      nzc <= '0;
      ex_en_inst <= 1'b0;
      ex_imm <= 1'b0;
      ex_instruction <= '0;
      ex_s <= 1'b0;
      ex_imm_operand <= '0;
      ex_imm_shift <= '0;
      ex_stype <= '0;
      retire <= 1'b0;
      skipped <= 1'b0;
      illegal <= 1'b0;
    end else begin
      ex_en_inst <= state_n == S_ISSUE || state_n == S_WB;
      retire <= wb;
      skipped <= state == S_DECODE && !bad && !go;
      illegal <= state == S_DECODE && bad;
      if (in_valid && in_ready) ir <= in_instr;
      if (wb) nzc <= {ex_neg_out, ex_zero_out, ex_carry_out};
      if (go) begin
        ex_imm <= i_bit;
        ex_instruction <= {1'b0, op};
        ex_s <= ir[20];
        ex_imm_operand <= ir[11:0];
        ex_imm_shift <= ir[11:7];
        ex_stype <= ir[6:5];
      end
    end
  op_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst), .re(go), .ra_a(rn), .ra_b(rm), .rd_a(ex_rn), .rd_b(ex_rm),
    .we(wb), .wa(rd), .wd(ex_rd), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
endmodule

// File: tb/tb_op_issue.sv
// tb_op_issue: scoreboard bench for op_issue with a behavioural op_add model closing the loop
module tb_op_issue;
  logic clk, rst, in_valid, in_ready, ex_en_inst, ex_imm, ex_s;
  logic [31:0] in_instr, ex_rn, ex_rm, ex_rd, dbg_data;
  logic [4:0] ex_instruction, ex_imm_shift;
  logic [11:0] ex_imm_operand;
  logic [1:0] ex_stype;
  logic ex_carry_in, ex_zero_in, ex_neg_in, ex_carry_out, ex_zero_out, ex_neg_out;
  logic retire, skipped, illegal;
  logic [2:0] flags;
  logic [3:0] dbg_addr, stim_addr, mon_addr;
  logic mon_busy;
  logic [32:0] sum;
  logic [31:0] op2v;
  int checks = 0, failures = 0, en_cnt = 0;
  typedef struct {logic [2:0] kind; logic [3:0] rd; logic [31:0] val; logic [2:0] nzc;} exp_t;
  exp_t sb[$];
  op_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ex_en_inst(ex_en_inst), .ex_imm(ex_imm), .ex_instruction(ex_instruction), .ex_s(ex_s),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_imm_operand(ex_imm_operand), .ex_imm_shift(ex_imm_shift),
    .ex_stype(ex_stype), .ex_carry_in(ex_carry_in), .ex_zero_in(ex_zero_in), .ex_neg_in(ex_neg_in),
    .ex_rd(ex_rd), .ex_carry_out(ex_carry_out), .ex_zero_out(ex_zero_out), .ex_neg_out(ex_neg_out),
    .retire(retire), .skipped(skipped), .illegal(illegal), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  assign dbg_addr = mon_busy ? mon_addr : stim_addr;
  always_comb begin
    op2v = ex_imm ? {20'b0, ex_imm_operand} : ex_rm << ex_imm_shift;
    sum = {1'b0, ex_rn} + {1'b0, op2v} + {32'b0, ex_instruction == 5'b00101 && ex_carry_in};
    ex_rd = sum[31:0];
    ex_carry_out = ex_s ? sum[32] : ex_carry_in;
    ex_zero_out = ex_s ? sum[31:0] == 32'b0 : ex_zero_in;
    ex_neg_out = ex_s ? sum[31] : ex_neg_in;
  end
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_op(input logic [2:0] kind, input logic [3:0] rd, input logic [31:0] val, input logic [2:0] nzc);
    exp_t e;
    e.kind = kind; e.rd = rd; e.val = val; e.nzc = nzc;
    sb.push_back(e);
  endtask
  task automatic send(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic run(input logic [31:0] w);
    send(w);
    repeat (4) @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t e;
    mon_busy = 1'b0;
    mon_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) en_cnt = 0;
      else begin
        if (ex_en_inst) en_cnt++;
        if (retire || skipped || illegal) begin
          if (sb.size() == 0) chk("unexpected_pulse", {29'b0, retire, skipped, illegal}, 32'd0);
          else begin
            e = sb.pop_front();
            chk("pulse_kind", {29'b0, retire, skipped, illegal}, {29'b0, e.kind});
            chk("en_cycles", en_cnt, e.kind == 3'b100 ? 32'd2 : 32'd0);
            chk("flags", {29'b0, flags}, {29'b0, e.nzc});
            mon_addr = e.rd;
            mon_busy = 1'b1;
            #1;
            chk("rd_value", dbg_data, e.val);
            mon_busy = 1'b0;
          end
          en_cnt = 0;
        end
      end
    end
  end
  initial begin
    logic [31:0] w [3];
    int cyc, last, k, busy;
    w[0] = 32'hE0916002;
    w[1] = 32'hE2B67001;
    w[2] = 32'hE2966FFF;
    rst = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    stim_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_en", {31'b0, ex_en_inst}, 32'd0);
    chk("rst_flags", {29'b0, flags}, 32'd0);
    rst = 1'b1;
    expect_op(3'b100, 4'd1, 32'd5, 3'b000);
    run(32'hE2901005);
    expect_op(3'b100, 4'd2, 32'h1004, 3'b000);
    run(32'hE2912FFF);
    expect_op(3'b100, 4'd3, 32'd0, 3'b010);
    run(32'hE2903000);
    expect_op(3'b100, 4'd4, 32'd7, 3'b010);
    run(32'h02804007);
    expect_op(3'b010, 4'd5, 32'd0, 3'b010);
    run(32'h12805007);
    expect_op(3'b001, 4'd1, 32'd5, 3'b010);
    run(32'hE2401001);
    expect_op(3'b001, 4'd15, 32'd0, 3'b010);
    run(32'hE290F005);
    expect_op(3'b100, 4'd6, 32'h1009, 3'b000);
    expect_op(3'b100, 4'd7, 32'h100A, 3'b000);
    expect_op(3'b100, 4'd6, 32'h2008, 3'b000);
    cyc = 0; last = 0; k = 0; busy = 0;
    in_valid = 1'b1;
    in_instr = w[0];
    while (k < 3 && cyc < 60) begin
      if (in_ready) begin
        if (k > 0) chk("accept_gap", cyc - last, 32'd4);
        last = cyc;
        @(posedge clk); #1;
        cyc++;
        k++;
        if (k < 3) in_instr = w[k];
      end else begin
        @(posedge clk); #1;
        cyc++;
        busy++;
      end
    end
    in_valid = 1'b0;
    chk("accepted", k, 32'd3);
    chk("busy_cycles", busy, 32'd6);
    repeat (4) @(posedge clk);
    #1;
    send(32'hE2819001);
    @(posedge clk); #2;
    chk("issue_en", {31'b0, ex_en_inst}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_en_drop", {31'b0, ex_en_inst}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_flags", {29'b0, flags}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      stim_addr = i[3:0];
      #0.1;
      chk("rst_reg", dbg_data, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    stim_addr = 4'd9;
    #1;
    chk("no_wb_r9", dbg_data, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
